// File: rtl/data_memory_dumper_pkg.sv
// rtl/data_memory_dumper_pkg.sv - shared encodings and constants for the data memory dumper
// Checksum states exist only when MEM_DUMP_CHECKSUM_EN is defined.
package data_memory_dumper_pkg;

  localparam int TAM_BYTE       = 8;
  localparam int DEF_TAM_DATA   = 32;
  localparam int BYTES_PER_WORD = DEF_TAM_DATA / TAM_BYTE;

  localparam logic [7:0] CHK_SEED = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_LATCH    = 4'd2,
    ST_SEND     = 4'd3,
    ST_WAIT_TX  = 4'd4,
    ST_NEXT     = 4'd5,
    ST_FINISH   = 4'd6
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    ST_CHK_SEND = 4'd7,
    ST_CHK_WAIT = 4'd8
`endif
  } state_t;

endpackage

// File: rtl/data_memory_dumper_uart_tx.sv
// rtl/data_memory_dumper_uart_tx.sv - one-cycle start pulse towards the UART TX and done tracking
// The byte is presented combinationally in the start cycle and held until the UART reports done.
module uart_tx_handshake_driver
  import data_memory_dumper_pkg::*;
#(
  parameter int W = TAM_BYTE
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_send,
  input  logic [W-1:0] i_byte,
  input  logic         i_tx_done,
  output logic [W-1:0] o_tx_data,
  output logic         o_tx_start,
  output logic         o_byte_done
);

  logic [W-1:0] r_hold;
  logic         r_pending;

  // Only a done that answers our own start counts; a stray or post-reset done is dropped.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else if (i_send) begin
      r_hold    <= i_byte;
      r_pending <= 1'b1;
    end else if (r_pending && i_tx_done) begin
      r_pending <= 1'b0;
    end
  end

  assign o_tx_start  = i_send;
  assign o_tx_data   = i_send ? i_byte : r_hold;
  assign o_byte_done = r_pending & i_tx_done;

endmodule

// File: rtl/data_memory_dumper.sv
// rtl/data_memory_dumper.sv - walks the data memory debug port and streams each word MSB byte first
// Optional MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module data_memory_dumper #(
  parameter int TAM_DATA  = 32,
  parameter int NUM_DIREC = 7,
  parameter int NUM_WORDS = 128,
  parameter int TAM_BYTE  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [TAM_DATA-1:0]  i_debug_read,
  output logic [NUM_DIREC-1:0] o_debug_pointer,
  output logic [TAM_BYTE-1:0]  o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  import data_memory_dumper_pkg::*;

  localparam int BPW   = TAM_DATA / TAM_BYTE;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [NUM_DIREC-1:0] LAST_PTR  = NUM_DIREC'(NUM_WORDS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [NUM_DIREC-1:0] r_ptr;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [TAM_DATA-1:0]  r_word;
  logic                 w_send;
  logic                 w_byte_done;
  logic [TAM_BYTE-1:0]  w_word_byte;
  logic [TAM_BYTE-1:0]  w_send_byte;
  logic                 w_last_byte;
  logic                 w_last_word;

  assign w_word_byte     = r_word[TAM_DATA-1 -: TAM_BYTE];
  assign w_last_byte     = (r_byte_cnt == LAST_BYTE);
  assign w_last_word     = (r_ptr == LAST_PTR);
  assign o_debug_pointer = r_ptr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next_state = ST_ADDR;
      ST_ADDR:    w_next_state = ST_LATCH;
      ST_LATCH:   w_next_state = ST_SEND;
      ST_SEND:    w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: if (w_byte_done) w_next_state = w_last_byte ? ST_NEXT : ST_SEND;
      ST_NEXT: begin
        if (!w_last_word) begin
          w_next_state = ST_ADDR;
        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
          w_next_state = ST_CHK_SEND;
`else
          w_next_state = ST_FINISH;
`endif
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CHK_SEND: w_next_state = ST_CHK_WAIT;
      ST_CHK_WAIT: if (w_byte_done) w_next_state = ST_FINISH;
`endif
      ST_FINISH:  w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Busy drops in the FINISH cycle so it never overlaps the done pulse.
  always_comb begin
    w_send = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE:   ;
      ST_SEND: begin
        w_send = 1'b1;
        o_busy = 1'b1;
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CHK_SEND: begin
        w_send = 1'b1;
        o_busy = 1'b1;
      end
`endif
      ST_FINISH: o_done = 1'b1;
      default:   o_busy = 1'b1;
    endcase
  end

  // The pointer is left on the last word after a dump; only a new start rewinds it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_ptr      <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_LATCH: r_word <= i_debug_read;
        ST_WAIT_TX: begin
          if (w_byte_done && !w_last_byte) begin
            r_word     <= r_word << TAM_BYTE;
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (!w_last_word) begin
            r_ptr      <= r_ptr + 1'b1;
            r_byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [TAM_BYTE-1:0] r_chk;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_chk <= TAM_BYTE'(CHK_SEED);
    end else if (r_state == ST_IDLE && i_start) begin
      r_chk <= TAM_BYTE'(CHK_SEED);
    end else if (r_state == ST_SEND) begin
      r_chk <= r_chk ^ w_word_byte;
    end
  end

  assign w_send_byte = (r_state == ST_CHK_SEND) ? r_chk : w_word_byte;
`else
  assign w_send_byte = w_word_byte;
`endif

  uart_tx_handshake_driver #(
    .W (TAM_BYTE)
  ) u_tx_driver (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_send      (w_send),
    .i_byte      (w_send_byte),
    .i_tx_done   (i_tx_done),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_byte_done (w_byte_done)
  );

endmodule

// File: tb/tb_data_memory_dumper.sv
// tb/tb_data_memory_dumper.sv - randomized bench for data_memory_dumper against a byte-stream model
// Honours MEM_DUMP_CHECKSUM_EN by expecting the trailing XOR byte.
module tb_data_memory_dumper;

  localparam int TAM_DATA  = 32;
  localparam int NUM_DIREC = 7;
  localparam int NUM_WORDS = 128;
  localparam int TAM_BYTE  = 8;
  localparam int BPW       = TAM_DATA / 8;
  localparam int TIMEOUT   = 12000;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_start;
  logic [TAM_DATA-1:0]  i_debug_read;
  logic [NUM_DIREC-1:0] o_debug_pointer;
  logic [TAM_BYTE-1:0]  o_tx_data;
  logic                 o_tx_start;
  logic                 i_tx_done;
  logic                 o_busy;
  logic                 o_done;

  logic [TAM_DATA-1:0]  mem [0:(2**NUM_DIREC)-1];
  logic [7:0]           got_q [$];
  logic [7:0]           exp_q [$];
  int                   hold_abs;
  int                   viol;
  int                   n_checks;
  int                   n_errors;

  always #5 clk = ~clk;

  data_memory_dumper #(
    .TAM_DATA  (TAM_DATA),
    .NUM_DIREC (NUM_DIREC),
    .NUM_WORDS (NUM_WORDS),
    .TAM_BYTE  (TAM_BYTE)
  ) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_debug_read    (i_debug_read),
    .o_debug_pointer (o_debug_pointer),
    .o_tx_data       (o_tx_data),
    .o_tx_start      (o_tx_start),
    .i_tx_done       (i_tx_done),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  // Registered debug read port
  always @(posedge clk) i_debug_read <= mem[o_debug_pointer];

  // UART TX responder: records every byte, answers after a delay, watches hold stability
  initial begin
    i_tx_done = 1'b0;
    viol = 0;
    @(negedge clk);
    forever begin
      if (o_tx_start) begin
        logic [7:0] b;
        int d;
        b = o_tx_data;
        d = (got_q.size() == hold_abs) ? 40 : int'($urandom_range(1, 6));
        got_q.push_back(b);
        repeat (d) begin
          @(negedge clk);
          if (o_busy && (o_tx_start || o_tx_data !== b)) viol++;
        end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic build_expected();
    logic [7:0] x;
    logic [7:0] v;
    exp_q.delete();
    x = 8'h00;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = BPW - 1; b >= 0; b--) begin
        v = 8'(mem[w] >> (8 * b));
        exp_q.push_back(v);
        x = x ^ v;
      end
    end
    if (CHK_EN) exp_q.push_back(x);
  endtask

  task automatic run_dump(input string tag, input int hold_rel, input bit inj_busy, input bit inj_finish);
    int base, nstart, first_tx, dones, viol0;
    logic [NUM_DIREC-1:0] pmax;
    bit injected, seen_done;
    build_expected();
    base = got_q.size();
    hold_abs = (hold_rel >= 0) ? base + hold_rel : -1;
    viol0 = viol;
    nstart = 0; first_tx = -1; dones = 0; pmax = '0; injected = 0; seen_done = 0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc <= TIMEOUT && !seen_done; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (cyc == 1) check_eq($sformatf("%s busy_after_start", tag), 32'(o_busy), 32'd1);
      if (o_tx_start) begin
        nstart++;
        if (first_tx < 0) first_tx = cyc;
      end
      if (o_debug_pointer > pmax) pmax = o_debug_pointer;
      if (inj_busy && !injected && o_debug_pointer == NUM_DIREC'(1)) begin
        i_start = 1'b1;
        injected = 1'b1;
      end
      if (o_done) begin
        seen_done = 1'b1;
        dones++;
        check_eq($sformatf("%s busy_at_done", tag), 32'(o_busy), 32'd0);
        if (inj_finish) i_start = 1'b1;
      end
    end
    check_eq($sformatf("%s done_seen", tag), 32'(seen_done), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) dones++;
      if (o_tx_start) nstart++;
    end
    check_eq($sformatf("%s idle_after", tag), 32'(o_busy), 32'd0);
    check_eq($sformatf("%s done_pulses", tag), 32'(dones), 32'd1);
    check_eq($sformatf("%s first_latency", tag), 32'(first_tx), 32'd3);
    check_eq($sformatf("%s start_pulses", tag), 32'(nstart), 32'(exp_q.size()));
    check_eq($sformatf("%s byte_count", tag), 32'(got_q.size() - base), 32'(exp_q.size()));
    check_eq($sformatf("%s ptr_max", tag), 32'(pmax), 32'(NUM_WORDS - 1));
    check_eq($sformatf("%s ptr_hold", tag), 32'(o_debug_pointer), 32'(NUM_WORDS - 1));
    check_eq($sformatf("%s hold_viol", tag), 32'(viol - viol0), 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        check_eq($sformatf("%s byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_abort();
    int nstart, base2, activity;
    bit fired;
    hold_abs = -1;
    nstart = 0; fired = 0; activity = 0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc <= TIMEOUT && !fired; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_tx_start) begin
        nstart++;
        if (nstart == 2 * BPW + 2) begin
          i_reset = 1'b1;
          fired = 1'b1;
        end
      end
    end
    check_eq("abort reached", 32'(fired), 32'd1);
    @(negedge clk);
    i_reset = 1'b0;
    check_eq("abort ptr", 32'(o_debug_pointer), 32'd0);
    check_eq("abort tx_data", 32'(o_tx_data), 32'd0);
    check_eq("abort tx_start", 32'(o_tx_start), 32'd0);
    check_eq("abort busy", 32'(o_busy), 32'd0);
    check_eq("abort done", 32'(o_done), 32'd0);
    base2 = got_q.size();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tx_start || o_busy || o_done) activity++;
    end
    check_eq("abort quiet", 32'(activity), 32'd0);
    check_eq("abort no_bytes", 32'(got_q.size() - base2), 32'd0);
  endtask

  logic [7:0] basic_exp [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_reset  = 1'b1;
    i_start  = 1'b0;
    hold_abs = -1;
    for (int k = 0; k < 2**NUM_DIREC; k++) mem[k] = $urandom;
    repeat (3) @(negedge clk);
    check_eq("reset ptr", 32'(o_debug_pointer), 32'd0);
    check_eq("reset tx_data", 32'(o_tx_data), 32'd0);
    check_eq("reset tx_start", 32'(o_tx_start), 32'd0);
    check_eq("reset busy", 32'(o_busy), 32'd0);
    check_eq("reset done", 32'(o_done), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    mem[2] = 32'h00000000;
    mem[3] = 32'hFFFFFFFF;
    run_dump("basic", -1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k < got_q.size()) check_eq($sformatf("basic_head%0d", k), 32'(got_q[k]), 32'(basic_exp[k]));
    end

    for (int k = 1; k < 2**NUM_DIREC; k++) mem[k] = $urandom;
    run_dump("hold", 2, 1'b0, 1'b0);

    for (int k = 0; k < 2**NUM_DIREC; k++) mem[k] = $urandom;
    run_dump("ignore", -1, 1'b1, 1'b1);

    run_abort();
    run_dump("redump", -1, 1'b0, 1'b0);

    for (int k = 0; k < 2**NUM_DIREC; k++) mem[k] = TAM_DATA'(k);
    run_dump("full", -1, 1'b0, 1'b0);
    if (got_q.size() > (CHK_EN ? 1 : 0))
      check_eq("full last_data_byte", 32'(got_q[got_q.size() - 1 - (CHK_EN ? 1 : 0)]), 32'h7F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
